// File: rtl/uno_hand_render_ctrl.sv
// Player-hand owner and glyph scheduler: edits the hand through a valid/ready command port,
// latches a tear-free display copy once per frame, and selects the owning card slot per pixel.
module uno_hand_render_ctrl #(
  parameter int MAX_CARDS = 8,
  parameter int CARD_W    = 30,
  parameter int CARD_H    = 50,
  parameter int X_ORIGIN  = 40,
  parameter int Y_ORIGIN  = 400,
  parameter int X_STEP    = 36
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [9:0] x_cnt,
  input  logic [9:0] y_cnt,
  input  logic       frame_start,
  input  logic       cmd_valid,
  output logic       cmd_ready,
  input  logic [1:0] cmd_op,
  input  logic [2:0] cmd_idx,
  input  logic [1:0] cmd_color,
  input  logic [3:0] cmd_num,
  output logic       cmd_err,
  output logic [3:0] card_count,
  output logic       pix_hit,
  output logic [9:0] glyph_x_pin,
  output logic [9:0] glyph_y_pin,
  output logic [1:0] glyph_color,
  output logic [3:0] glyph_num
);

  typedef enum logic [1:0] {IDLE, SHIFT, COMMIT} state_e;
  typedef enum logic [1:0] {OP_ADD = 2'b00, OP_REMOVE = 2'b01, OP_CLEAR = 2'b10, OP_RSVD = 2'b11} op_e;
  typedef struct packed {
    logic [1:0] color;
    logic [3:0] num;
  } card_t;

  state_e     state_q, state_d;
  logic [2:0] ptr_q, ptr_d;
  logic [3:0] edit_cnt_q, edit_cnt_d;
  logic [3:0] disp_cnt_q;
  card_t      edit_q [MAX_CARDS];
  card_t      edit_d [MAX_CARDS];
  card_t      disp_q [MAX_CARDS];
  logic       pend_q, pend_d;
  logic       err_q, err_d;
  logic       hs, copy;

  logic       hit_q, hit_d;
  logic [9:0] gx_q, gx_d, gy_q, gy_d;
  logic [1:0] gc_q, gc_d;
  logic [3:0] gn_q, gn_d;

  function automatic logic [10:0] slot_x(int i);
    return 11'(X_ORIGIN + i * X_STEP);
  endfunction

  function automatic logic in_slot(int i, logic [9:0] x, logic [9:0] y);
    logic [10:0] xp, yp;
    xp = slot_x(i);
    yp = 11'(Y_ORIGIN);
    return ({1'b0, x} >= xp) && ({1'b0, x} <= xp + 11'(CARD_W)) &&
           ({1'b0, y} >= yp) && ({1'b0, y} <= yp + 11'(CARD_H));
  endfunction

  // A pending copy steals one IDLE cycle, so the port is closed while it is owed.
  assign cmd_ready = (state_q == IDLE) && !pend_q;
  assign hs        = cmd_valid && cmd_ready;
  assign copy      = (state_q == IDLE) && !hs && (frame_start || pend_q);

  // NOTE: every _d gets its default first so no path through the case leaves a latch.
  always_comb begin
    state_d    = state_q;
    ptr_d      = ptr_q;
    edit_cnt_d = edit_cnt_q;
    edit_d     = edit_q;
    err_d      = 1'b0;
    pend_d     = pend_q;
    if (copy)             pend_d = 1'b0;
    else if (frame_start) pend_d = 1'b1;

    unique case (state_q)
      IDLE: begin
        if (hs) begin
          unique case (op_e'(cmd_op))
            OP_ADD: begin
              if (edit_cnt_q < 4'(MAX_CARDS)) begin
                for (int i = 0; i < MAX_CARDS; i++)
                  if (4'(i) == edit_cnt_q) edit_d[i] = '{color: cmd_color, num: cmd_num};
                edit_cnt_d = edit_cnt_q + 4'd1;
              end else begin
                err_d = 1'b1;
              end
            end
            OP_REMOVE: begin
              if ({1'b0, cmd_idx} < edit_cnt_q) begin
                ptr_d   = cmd_idx;
                state_d = SHIFT;
              end else begin
                err_d = 1'b1;
              end
            end
            OP_CLEAR: edit_cnt_d = 4'd0;
            OP_RSVD:  err_d = 1'b1;
            default:  err_d = 1'b1;
          endcase
        end
      end
      SHIFT: begin
        if ((4'(ptr_q) + 4'd1) < edit_cnt_q) begin
          for (int i = 0; i < MAX_CARDS - 1; i++)
            if (3'(i) == ptr_q) edit_d[i] = edit_q[i+1];
          ptr_d = ptr_q + 3'd1;
        end else begin
          state_d = COMMIT;
        end
      end
      COMMIT: begin
        edit_cnt_d = edit_cnt_q - 4'd1;
        state_d    = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // Descending scan so the lowest-numbered overlapping slot is the last writer.
  always_comb begin
    hit_d = 1'b0;
    gx_d  = '0;
    gy_d  = '0;
    gc_d  = '0;
    gn_d  = '0;
    for (int i = MAX_CARDS - 1; i >= 0; i--) begin
      if ((4'(i) < disp_cnt_q) && in_slot(i, x_cnt, y_cnt)) begin
        hit_d = 1'b1;
        gx_d  = 10'(slot_x(i));
        gy_d  = 10'(Y_ORIGIN);
        gc_d  = disp_q[i].color;
        gn_d  = disp_q[i].num;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      ptr_q      <= '0;
      edit_cnt_q <= '0;
      disp_cnt_q <= '0;
      pend_q     <= 1'b0;
      err_q      <= 1'b0;
      hit_q      <= 1'b0;
      gx_q       <= '0;
      gy_q       <= '0;
      gc_q       <= '0;
      gn_q       <= '0;
    end else begin
      state_q    <= state_d;
      ptr_q      <= ptr_d;
      edit_cnt_q <= edit_cnt_d;
      pend_q     <= pend_d;
      err_q      <= err_d;
      hit_q      <= hit_d;
      gx_q       <= gx_d;
      gy_q       <= gy_d;
      gc_q       <= gc_d;
      gn_q       <= gn_d;
      if (copy) disp_cnt_q <= edit_cnt_q;
    end
  end

  // NOTE: slot storage is left unreset; the counts alone define which slots are live.
  always_ff @(posedge clk) begin
    edit_q <= edit_d;
    if (copy) disp_q <= edit_q;
  end

  assign cmd_err     = err_q;
  assign card_count  = edit_cnt_q;
  assign pix_hit     = hit_q;
  assign glyph_x_pin = gx_q;
  assign glyph_y_pin = gy_q;
  assign glyph_color = gc_q;
  assign glyph_num   = gn_q;

endmodule
